wb_commit_stage: RTL and testbench
==================================

# wb_commit_stage

Parametrised multi-lane write-back/commit stage. Resolves the branch condition of each lane against its flags, commits lanes in order up to and including the first taken branch, and squashes younger lanes. Registers the committed register-file writes behind a valid/ready handshake with a one-entry skid buffer, and issues a single-cycle redirect to fetch. Sits between the memory stage and the register file. It supersedes the single-lane, non-stalling write-back register.

## Interface
Parameters:
- XLEN, 32: data and PC width.
- LANES, 2: instructions per beat (1..4); lane 0 is oldest.
- REG_AW, 5: register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_lane  in  LANES x WbLane  per lane: valid, pc (fall-through), branch (target), cond, flags{zero,carry}, wback, wreg, wdata.
- out_valid  out  1  committed beat valid.
- out_ready  in  1  register file/retire accepts the beat.
- out_lane  out  LANES x WbCommit  per lane: valid, wback, wreg, wdata.
- commit_pc  out  XLEN  next PC after the last committed lane of the output beat.
- redirect_valid  out  1  one-cycle redirect pulse to fetch.
- redirect_pc  out  XLEN  redirect target.

## Operation
- Per-lane target:
  - Zero: branch if flags.zero = 1, else pc.
  - NotZero: branch if flags.zero = 0, else pc.
  - Carry: branch if flags.carry = 1, else pc.
  - NotCarry: branch if flags.carry = 0, else pc.
  - Never: pc.
  - Always: branch.
  - Any other encoding: target 0, counted as taken.
- Taken means the lane selects branch, or the cond encoding is illegal.
- Kill lane k = lowest-index valid lane that is taken. Lanes above k get committed valid = 0. Lanes at or below k keep their input valid.
- commit_pc = target of the highest committed valid lane. If no lane is valid, commit_pc holds its previous value.
- Accept = in_valid && in_ready.
- If a kill lane exists on an accepted beat:
  - redirect_valid = 1 and redirect_pc = its target on the next cycle, for exactly one cycle.
  - Not gated by out_ready.
- Wrong-path drop: a beat accepted in a cycle where redirect_valid = 1 is consumed and discarded. It is never presented on out_*, and it cannot itself redirect.
- Buffer FSM over main and skid registers:
  - EMPTY: accept -> FULL1.
  - FULL1:
    - accept and out_ready -> FULL1 (replace main).
    - accept and !out_ready -> FULL2 (beat into skid).
    - !accept and out_ready -> EMPTY.
  - FULL2: out_ready -> FULL1 (skid moves to main); no accept is possible in this state.
- in_ready = !(state == FULL2), and 0 while rst is high.
- out_valid = state != EMPTY. out_lane and commit_pc come from the main register.
- Output is stable while out_valid && !out_ready.
- Widths: all PC math is XLEN wide; there is no arithmetic. cond is an enum from the package.

## Timing
- Latency: 1 cycle from accept to out_valid, and 1 cycle from accept to redirect_valid.
- Throughput: 1 beat/cycle while out_ready = 1.
- Reset (asynchronous assert, synchronous release):
  - state EMPTY.
  - out_valid, out_lane (all fields), commit_pc, redirect_valid, redirect_pc = 0.
  - in_ready = 0 while asserted, 1 from the first cycle after release.
- Reset mid-operation: buffered beats and a pending redirect are lost and no pulse is emitted.
- Back-to-back taken beats: the second is dropped as wrong-path, so pulses never occur on consecutive cycles.
- Accept and drain in the same cycle in FULL1: the new beat replaces main with no bubble.

## Configuration
- WB_RETIRE_CNT_EN defined:
  - Adds output retire_count (64-bit).
  - Increments by the number of committed valid lanes of each beat in the cycle that beat handshakes on out_*.
  - Resets to 0 and wraps modulo 2^64.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package Common holds:
  - the Cond enum (Zero, NotZero, Carry, NotCarry, Never, Always);
  - the Flags struct;
  - the WbLane and WbCommit packed structs, parametrised by XLEN/REG_AW via package localparams.
- Sub-module wb_cond_resolve (combinational, one instance per lane) maps cond, flags, pc and branch to target and taken.
- The FSM, kill logic and optional counter stay in wb_commit_stage.

## Test plan
- LANES = 2, lane0 cond = NotZero with zero = 0, branch = 0x100; lane1 valid. Expect: out lane1.valid = 0, commit_pc = 0x100, redirect_valid = 1 for one cycle with redirect_pc = 0x100.
- Both lanes cond = Never, pc 0x8/0xC. Expect: both committed, commit_pc = 0xC, no redirect.
- Hold out_ready = 0 and present 3 beats. Expect: 2 accepted, in_ready = 0 afterwards, outputs stable. Then release out_ready. Expect: beats drain in order, no loss.
- Taken beat followed immediately by a valid beat. Expect: second beat consumed and absent from out_*.
- Illegal cond on lane0. Expect: redirect_pc = 0, lane1 squashed.
- Assert rst while in FULL2. Expect: out_valid = 0 and redirect_valid = 0 immediately. With WB_RETIRE_CNT_EN defined, expect retire_count = 0 after reset, and +2 per fully committed 2-lane beat afterwards.

Source files
------------

// File: rtl/wb_commit_stage_pkg.sv
// Shared types for the write-back/commit stage: branch conditions, flags, lane records
// and the output buffer state encoding.
package wb_commit_stage_pkg;

  localparam int unsigned PkgXlen  = 32;
  localparam int unsigned PkgRegAw = 5;

  typedef enum logic [2:0] {
    CondZero     = 3'd0,
    CondNotZero  = 3'd1,
    CondCarry    = 3'd2,
    CondNotCarry = 3'd3,
    CondNever    = 3'd4,
    CondAlways   = 3'd5
  } cond_e;

  typedef struct packed {
    logic zero;
    logic carry;
  } flags_t;

  typedef struct packed {
    logic                valid;
    logic [PkgXlen-1:0]  pc;
    logic [PkgXlen-1:0]  branch;
    cond_e               cond;
    flags_t              flags;
    logic                wback;
    logic [PkgRegAw-1:0] wreg;
    logic [PkgXlen-1:0]  wdata;
  } wb_lane_t;

  typedef struct packed {
    logic                valid;
    logic                wback;
    logic [PkgRegAw-1:0] wreg;
    logic [PkgXlen-1:0]  wdata;
  } wb_commit_t;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull1 = 2'd1,
    StFull2 = 2'd2
  } buf_state_e;

endpackage

// File: rtl/wb_commit_stage_cond.sv
// Per-lane branch resolution: picks branch or fall-through PC from cond and flags.
// Illegal cond encodings resolve to target 0 and count as taken.
module wb_cond_resolve
  import wb_commit_stage_pkg::*;
#(
  parameter int unsigned XLEN = PkgXlen
) (
  input  cond_e            cond,
  input  flags_t           flags,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  branch,
  output logic [XLEN-1:0]  target,
  output logic             taken
);

  logic sel;
  logic legal;

  always_comb begin
    sel   = 1'b0;
    legal = 1'b1;
    case (cond)
      CondZero:     sel = flags.zero;
      CondNotZero:  sel = !flags.zero;
      CondCarry:    sel = flags.carry;
      CondNotCarry: sel = !flags.carry;
      CondNever:    sel = 1'b0;
      CondAlways:   sel = 1'b1;
      default:      legal = 1'b0;
    endcase
    taken  = sel || !legal;
    target = !legal ? '0 : (sel ? branch : pc);
  end

endmodule

// File: rtl/wb_commit_stage.sv
// Multi-lane commit stage: in-order commit up to the first taken branch, one-cycle redirect,
// and a main+skid output buffer. Define WB_RETIRE_CNT_EN to add the 64-bit retire_count port.
module wb_commit_stage
  import wb_commit_stage_pkg::*;
#(
  parameter int unsigned XLEN   = PkgXlen,
  parameter int unsigned LANES  = 2,
  parameter int unsigned REG_AW = PkgRegAw
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  wb_lane_t [LANES-1:0]    in_lane,
  output logic                    out_valid,
  input  logic                    out_ready,
  output wb_commit_t [LANES-1:0]  out_lane,
  output logic [XLEN-1:0]         commit_pc,
  output logic                    redirect_valid,
  output logic [XLEN-1:0]         redirect_pc
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]             retire_count
`endif
);

  logic [LANES-1:0][XLEN-1:0] target;
  logic [LANES-1:0]           taken;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    wb_cond_resolve #(
      .XLEN (XLEN)
    ) u_resolve (
      .cond   (in_lane[i].cond),
      .flags  (in_lane[i].flags),
      .pc     (in_lane[i].pc),
      .branch (in_lane[i].branch),
      .target (target[i]),
      .taken  (taken[i])
    );
  end

  wb_commit_t [LANES-1:0] beat_lane;
  logic [XLEN-1:0]        beat_pc;
  logic                   kill_found;
  logic [XLEN-1:0]        kill_pc;
  logic [XLEN-1:0]        last_pc_q;

  // A beat with no committed lane inherits the PC of the most recently buffered beat.
  always_comb begin
    kill_found = 1'b0;
    kill_pc    = '0;
    beat_pc    = last_pc_q;
    for (int i = 0; i < LANES; i++) begin
      beat_lane[i].valid = in_lane[i].valid && !kill_found;
      beat_lane[i].wback = in_lane[i].wback;
      beat_lane[i].wreg  = in_lane[i].wreg[REG_AW-1:0];
      beat_lane[i].wdata = in_lane[i].wdata;
      if (beat_lane[i].valid) beat_pc = target[i];
      if (in_lane[i].valid && taken[i] && !kill_found) begin
        kill_found = 1'b1;
        kill_pc    = target[i];
      end
    end
  end

  buf_state_e state_q, state_d;
  logic       take;
  logic       load_main;
  logic       load_skid;
  logic       skid_to_main;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StEmpty;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StEmpty: if (take) state_d = StFull1;
      StFull1: begin
        if (take && !out_ready)      state_d = StFull2;
        else if (!take && out_ready) state_d = StEmpty;
      end
      StFull2: if (out_ready) state_d = StFull1;
      default: state_d = StEmpty;
    endcase
  end

  // Beats accepted while a redirect is pulsing are wrong-path and never buffered.
  always_comb begin
    in_ready     = (state_q != StFull2) && !rst;
    out_valid    = (state_q != StEmpty);
    take         = in_valid && in_ready && !redirect_valid;
    load_main    = take && ((state_q == StEmpty) || ((state_q == StFull1) && out_ready));
    load_skid    = take && (state_q == StFull1) && !out_ready;
    skid_to_main = (state_q == StFull2) && out_ready;
  end

  wb_commit_t [LANES-1:0] main_lane_q, skid_lane_q;
  logic [XLEN-1:0]        main_pc_q, skid_pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_lane_q    <= '0;
      main_pc_q      <= '0;
      skid_lane_q    <= '0;
      skid_pc_q      <= '0;
      last_pc_q      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      if (load_main) begin
        main_lane_q <= beat_lane;
        main_pc_q   <= beat_pc;
      end else if (skid_to_main) begin
        main_lane_q <= skid_lane_q;
        main_pc_q   <= skid_pc_q;
      end
      if (load_skid) begin
        skid_lane_q <= beat_lane;
        skid_pc_q   <= beat_pc;
      end
      if (take) last_pc_q <= beat_pc;
      redirect_valid <= take && kill_found;
      if (take && kill_found) redirect_pc <= kill_pc;
    end
  end

  assign out_lane  = main_lane_q;
  assign commit_pc = main_pc_q;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_inc;

  always_comb begin
    retire_inc = '0;
    for (int i = 0; i < LANES; i++) retire_inc = retire_inc + 64'(main_lane_q[i].valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         retire_count <= '0;
    else if (out_valid && out_ready) retire_count <= retire_count + retire_inc;
  end
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// Self-checking bench for wb_commit_stage: directed vector table, hand sequences for
// stall/drop/reset corners, and randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_wb_commit_stage;
  import wb_commit_stage_pkg::*;

  localparam int unsigned LANES = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid;
  logic                   in_ready;
  wb_lane_t [LANES-1:0]   in_lane;
  logic                   out_valid;
  logic                   out_ready;
  wb_commit_t [LANES-1:0] out_lane;
  logic [31:0]            commit_pc;
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0]            retire_count;
`endif

  wb_commit_stage #(
    .XLEN   (32),
    .LANES  (LANES),
    .REG_AW (5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_lane        (in_lane),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_lane       (out_lane),
    .commit_pc      (commit_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_count   (retire_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    wb_commit_t [LANES-1:0] lanes;
    logic [31:0]            pc;
  } beat_t;

  beat_t       q[$];
  bit          m_redir;
  logic [31:0] m_rpc;
  logic [31:0] m_last_pc;
  logic [63:0] m_retire;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Branch rule straight from the condition table.
  task automatic resolve(input wb_lane_t l, output logic [31:0] tgt, output bit tk);
    bit legal;
    bit sel;
    legal = 1'b1;
    sel   = 1'b0;
    case (l.cond)
      CondZero:     sel = (l.flags.zero == 1'b1);
      CondNotZero:  sel = (l.flags.zero == 1'b0);
      CondCarry:    sel = (l.flags.carry == 1'b1);
      CondNotCarry: sel = (l.flags.carry == 1'b0);
      CondNever:    sel = 1'b0;
      CondAlways:   sel = 1'b1;
      default:      legal = 1'b0;
    endcase
    if (!legal) begin
      tgt = 32'h0;
      tk  = 1'b1;
    end else begin
      tgt = sel ? l.branch : l.pc;
      tk  = sel;
    end
  endtask

  task automatic build(output beat_t b, output bit kill, output logic [31:0] kt);
    int          k;
    logic [31:0] t;
    bit          tk;
    bit          got;
    k = LANES;
    for (int i = LANES - 1; i >= 0; i--) begin
      resolve(in_lane[i], t, tk);
      if (in_lane[i].valid && tk) k = i;
    end
    for (int i = 0; i < LANES; i++) begin
      b.lanes[i].valid = in_lane[i].valid && (i <= k);
      b.lanes[i].wback = in_lane[i].wback;
      b.lanes[i].wreg  = in_lane[i].wreg;
      b.lanes[i].wdata = in_lane[i].wdata;
    end
    b.pc = m_last_pc;
    got  = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (!got && b.lanes[i].valid) begin
        resolve(in_lane[i], t, tk);
        b.pc = t;
        got  = 1'b1;
      end
    end
    kill = (k < LANES);
    kt   = 32'h0;
    if (kill) begin
      resolve(in_lane[k], t, tk);
      kt = t;
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_redir   = 1'b0;
    m_rpc     = 32'h0;
    m_last_pc = 32'h0;
    m_retire  = 64'h0;
  endtask

  task automatic model_check();
    chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
    chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_lane", 128'(out_lane), 128'(q[0].lanes));
      chk("commit_pc", 128'(commit_pc), 128'(q[0].pc));
    end
    chk("redirect_valid", 128'(redirect_valid), 128'(m_redir));
    if (m_redir) chk("redirect_pc", 128'(redirect_pc), 128'(m_rpc));
`ifdef WB_RETIRE_CNT_EN
    chk("retire_count", 128'(retire_count), 128'(m_retire));
`endif
  endtask

  task automatic model_update();
    bit          acc;
    bit          hs;
    bit          kill;
    bit          new_redir;
    logic [31:0] kt;
    beat_t       b;
    acc       = in_valid && (q.size() < 2);
    hs        = out_ready && (q.size() > 0);
    new_redir = 1'b0;
    if (hs) begin
      for (int i = 0; i < LANES; i++) m_retire += 64'(q[0].lanes[i].valid);
      void'(q.pop_front());
    end
    if (acc && !m_redir) begin
      build(b, kill, kt);
      q.push_back(b);
      m_last_pc = b.pc;
      new_redir = kill;
      if (kill) m_rpc = kt;
    end
    m_redir = new_redir;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pair(input cond_e c0, input bit z0, input bit k0, input cond_e c1,
                          input bit z1, input bit k1, input bit v1);
    in_lane[0] = '{valid: 1'b1, pc: 32'h8, branch: 32'h100, cond: c0,
                   flags: '{zero: z0, carry: k0}, wback: 1'b1, wreg: 5'd3,
                   wdata: $urandom};
    in_lane[1] = '{valid: v1, pc: 32'hC, branch: 32'h200, cond: c1,
                   flags: '{zero: z1, carry: k1}, wback: 1'b1, wreg: 5'd7,
                   wdata: $urandom};
  endtask

  task automatic set_never(input logic [31:0] base);
    for (int i = 0; i < LANES; i++) begin
      in_lane[i] = '{valid: 1'b1, pc: base + 32'(4 * i), branch: 32'hDEAD0000, cond: CondNever,
                     flags: '{zero: 1'b0, carry: 1'b0}, wback: 1'b1, wreg: 5'(i + 1),
                     wdata: $urandom};
    end
  endtask

  typedef struct {
    cond_e       c0;
    bit          z0;
    bit          k0;
    cond_e       c1;
    bit          z1;
    bit          k1;
    bit          v1;
    bit          e_v1;
    logic [31:0] e_pc;
    bit          e_redir;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{CondNotZero, 0, 0, CondNever, 0, 0, 1, 0, 32'h100, 1, 32'h100};
    vecs[1] = '{CondNever, 0, 0, CondNever, 0, 0, 1, 1, 32'hC, 0, 32'h0};
    vecs[2] = '{cond_e'(3'd6), 0, 0, CondNever, 0, 0, 1, 0, 32'h0, 1, 32'h0};
    vecs[3] = '{CondZero, 0, 0, CondAlways, 0, 0, 1, 1, 32'h200, 1, 32'h200};
    vecs[4] = '{CondCarry, 0, 1, CondAlways, 0, 0, 1, 0, 32'h100, 1, 32'h100};
    vecs[5] = '{CondNotCarry, 0, 1, CondCarry, 0, 0, 1, 1, 32'hC, 0, 32'h0};
    vecs[6] = '{CondZero, 1, 0, CondNever, 0, 0, 1, 0, 32'h100, 1, 32'h100};
    vecs[7] = '{CondNever, 0, 0, CondAlways, 0, 0, 0, 0, 32'h8, 0, 32'h0};
    vecs[8] = '{CondNotCarry, 0, 0, CondNever, 0, 0, 1, 0, 32'h100, 1, 32'h100};
    vecs[9] = '{cond_e'(3'd7), 0, 0, CondAlways, 1, 0, 1, 0, 32'h0, 1, 32'h0};

    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_lane   = '0;
    model_reset();

    // Reset state while asserted.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_lane", 128'(out_lane), 128'(0));
    chk("rst_commit_pc", 128'(commit_pc), 128'(0));
    chk("rst_redirect_valid", 128'(redirect_valid), 128'(0));
    chk("rst_redirect_pc", 128'(redirect_pc), 128'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));

    // Directed vector table, one isolated beat each.
    foreach (vecs[v]) begin
      set_pair(vecs[v].c0, vecs[v].z0, vecs[v].k0, vecs[v].c1, vecs[v].z1, vecs[v].k1,
               vecs[v].v1);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_out_valid", v), 128'(out_valid), 128'(1));
      chk($sformatf("vec%0d_lane0_valid", v), 128'(out_lane[0].valid), 128'(1));
      chk($sformatf("vec%0d_lane1_valid", v), 128'(out_lane[1].valid), 128'(vecs[v].e_v1));
      chk($sformatf("vec%0d_commit_pc", v), 128'(commit_pc), 128'(vecs[v].e_pc));
      chk($sformatf("vec%0d_redirect", v), 128'(redirect_valid), 128'(vecs[v].e_redir));
      if (vecs[v].e_redir)
        chk($sformatf("vec%0d_redirect_pc", v), 128'(redirect_pc), 128'(vecs[v].e_rpc));
      cycle();
      chk($sformatf("vec%0d_pulse_once", v), 128'(redirect_valid), 128'(0));
      cycle();
    end

    // Stall: three beats offered with out_ready low, two fit.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_never(32'h18);
    cycle();
    set_never(32'h28);
    cycle();
    set_never(32'h38);
    cycle();
    chk("stall_in_ready", 128'(in_ready), 128'(0));
    chk("stall_commit_pc", 128'(commit_pc), 128'(32'h1C));
    cycle();
    chk("stall_hold_pc", 128'(commit_pc), 128'(32'h1C));
    out_ready = 1'b1;
    cycle();
    chk("drain_second", 128'(commit_pc), 128'(32'h2C));
    cycle();
    in_valid = 1'b0;
    chk("drain_third", 128'(commit_pc), 128'(32'h3C));
    repeat (3) cycle();

    // Taken beat followed immediately by a beat that must be dropped.
    set_pair(CondAlways, 0, 0, CondNever, 0, 0, 1);
    in_valid = 1'b1;
    cycle();
    set_never(32'h40);
    cycle();
    in_valid = 1'b0;
    chk("drop_out_valid", 128'(out_valid), 128'(0));
    chk("drop_no_pulse", 128'(redirect_valid), 128'(0));
    repeat (2) cycle();

    // Reset while FULL2 with a redirect pending.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_never(32'h60);
    cycle();
    set_pair(CondAlways, 0, 0, CondNever, 0, 0, 1);
    cycle();
    in_valid = 1'b0;
    chk("full2_in_ready", 128'(in_ready), 128'(0));
    chk("full2_redirect", 128'(redirect_valid), 128'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_redirect", 128'(redirect_valid), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(0));
    chk("midrst_commit_pc", 128'(commit_pc), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cycle();
`ifdef WB_RETIRE_CNT_EN
    chk("retire_after_rst", 128'(retire_count), 128'(0));
`endif
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_never(32'h80);
    cycle();
    set_never(32'h90);
    cycle();
    in_valid = 1'b0;
    cycle();
`ifdef WB_RETIRE_CNT_EN
    chk("retire_two_beats", 128'(retire_count), 128'(4));
`endif
    cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < LANES; i++) begin
        in_lane[i].valid  = ($urandom_range(0, 3) != 0);
        in_lane[i].pc     = $urandom;
        in_lane[i].branch = $urandom;
        in_lane[i].cond   = cond_e'(3'($urandom_range(0, 7)));
        in_lane[i].flags  = 2'($urandom);
        in_lane[i].wback  = 1'($urandom);
        in_lane[i].wreg   = 5'($urandom);
        in_lane[i].wdata  = $urandom;
      end
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
